// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
//   MEM-stage access controller. It sits between the EX/MEM latch and a
//   word-organised, combinationally read data memory. It handles byte,
//   halfword and word loads (lane extraction with sign/zero extension) and
//   stores (read-modify-write for sub-word sizes), and stalls the pipeline
//   while an access is in flight.
//
//   Optional build macro: DMEM_RANGE_CHECK_EN
//     When defined, the module has a range_err output. A request whose byte
//     address is >= 4*DEPTH completes immediately with range_err=1 and never
//     touches memory. When undefined, the upper address bits are ignored and
//     the word index wraps within DEPTH.
module dmem_access_ctrl #(
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned ADDR_W = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic        req_read,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        misalign_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_write_data,
   output logic        mem_memwrite,
   output logic        mem_memread,
`ifdef DMEM_RANGE_CHECK_EN
   output logic        range_err,
`endif
   input  logic [31:0] mem_read_data
);

   typedef enum logic [1:0] {
      IDLE,
      RD,
      WR,
      RESP
   } state_t;

   state_t            state;

   // Request fields latched at the accept edge.
   logic [ADDR_W+1:0] addr_q;
   logic [1:0]        size_q;
   logic              signed_q;
   logic              write_q;
   // Store data; after the read phase of a sub-word store it holds the merged word.
   logic [31:0]       wword_q;

   logic              is_op;
   logic              accept;
   logic              misaligned;
   logic              out_of_range;

   // Little-endian lane extraction followed by sign or zero extension.
   function automatic logic [31:0] load_extract(
      input logic [31:0] word,
      input logic [1:0]  lo,
      input logic [1:0]  size,
      input logic        sgn
   );
      logic [31:0] sh;
      logic [31:0] res;
      sh  = '0;
      res = word;
      case (size)
         2'b00: begin
            sh  = word >> {lo, 3'b000};
            res = sgn ? {{24{sh[7]}}, sh[7:0]} : {24'd0, sh[7:0]};
         end
         2'b01: begin
            sh  = word >> {lo[1], 4'b0000};
            res = sgn ? {{16{sh[15]}}, sh[15:0]} : {16'd0, sh[15:0]};
         end
         default: res = word;
      endcase
      return res;
   endfunction

   // Replace the addressed byte/half lanes of the old word with store data.
   function automatic logic [31:0] store_merge(
      input logic [31:0] old,
      input logic [31:0] wdata,
      input logic [1:0]  lo,
      input logic [1:0]  size
   );
      logic [31:0] mask;
      logic [31:0] data;
      mask = '1;
      data = wdata;
      case (size)
         2'b00: begin
            mask = 32'h0000_00FF << {lo, 3'b000};
            data = {24'd0, wdata[7:0]} << {lo, 3'b000};
         end
         2'b01: begin
            mask = 32'h0000_FFFF << {lo[1], 4'b0000};
            data = {16'd0, wdata[15:0]} << {lo[1], 4'b0000};
         end
         default: begin
            mask = '1;
            data = wdata;
         end
      endcase
      return (old & ~mask) | (data & mask);
   endfunction

   // Alignment rule: halves need addr[0]=0, words (and size 11) need addr[1:0]=0.
   always_comb begin
      misaligned = 1'b0;
      case (req_size)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = req_addr[0];
         default: misaligned = (req_addr[1:0] != 2'b00);
      endcase
   end

`ifdef DMEM_RANGE_CHECK_EN
   assign out_of_range = (req_addr >= 32'(4 * DEPTH));
`else
   logic unused_addr_hi;
   assign unused_addr_hi = ^req_addr[31:ADDR_W+2];
   assign out_of_range   = 1'b0;
`endif

   // A request counts only with a read or write flag; reset suppresses acceptance.
   assign is_op  = req_valid && (req_read || req_write);
   assign accept = rst && (state == IDLE) && is_op;

   // Stall covers the accept cycle and the memory phases, but not RESP.
   assign stall = accept || (state == RD) || (state == WR);

   // Memory-side outputs decoded from state and latched registers.
   assign mem_memread    = (state == RD);
   assign mem_memwrite   = (state == WR);
   assign mem_addr       = {{(32 - ADDR_W){1'b0}}, addr_q[ADDR_W+1:2]};
   assign mem_write_data = wword_q;

   // Access FSM with registered response outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= IDLE;
         addr_q       <= '0;
         size_q       <= '0;
         signed_q     <= 1'b0;
         write_q      <= 1'b0;
         wword_q      <= '0;
         resp_valid   <= 1'b0;
         resp_rdata   <= '0;
         misalign_err <= 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
         range_err    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (is_op) begin
                  addr_q   <= req_addr[ADDR_W+1:0];
                  size_q   <= req_size;
                  signed_q <= req_signed;
                  write_q  <= req_write;
                  wword_q  <= req_wdata;
                  if (misaligned || out_of_range) begin
                     state        <= RESP;
                     resp_valid   <= 1'b1;
                     resp_rdata   <= '0;
                     misalign_err <= misaligned;
`ifdef DMEM_RANGE_CHECK_EN
                     range_err    <= out_of_range;
`endif
                  end else if (req_write && req_size[1]) begin
                     state <= WR;
                  end else begin
                     state <= RD;
                  end
               end
            end
            RD: begin
               if (write_q) begin
                  wword_q <= store_merge(mem_read_data, wword_q, addr_q[1:0], size_q);
                  state   <= WR;
               end else begin
                  resp_rdata <= load_extract(mem_read_data, addr_q[1:0], size_q, signed_q);
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end
            end
            WR: begin
               resp_rdata <= '0;
               resp_valid <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               resp_valid   <= 1'b0;
               misalign_err <= 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
               range_err    <= 1'b0;
`endif
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl
//   Directed bench for dmem_access_ctrl with a 256-word behavioural memory.
//   Build with DMEM_RANGE_CHECK_EN defined to cover the range_err variant.
module tb_dmem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic        req_read = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        stall;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        misalign_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_write_data;
   logic        mem_memwrite;
   logic        mem_memread;
   logic        range_err;
   logic [31:0] mem_read_data;

   logic [31:0] dmem [0:255];
   logic        mem_init = 1'b1;

   int n_checks = 0;
   int n_bad    = 0;

   always #5 clk = ~clk;

   dmem_access_ctrl #(.DEPTH(256), .ADDR_W(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_write      (req_write),
      .req_read       (req_read),
      .req_size       (req_size),
      .req_signed     (req_signed),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .stall          (stall),
      .resp_valid     (resp_valid),
      .resp_rdata     (resp_rdata),
      .misalign_err   (misalign_err),
      .mem_addr       (mem_addr),
      .mem_write_data (mem_write_data),
      .mem_memwrite   (mem_memwrite),
      .mem_memread    (mem_memread),
`ifdef DMEM_RANGE_CHECK_EN
      .range_err      (range_err),
`endif
      .mem_read_data  (mem_read_data)
   );

`ifndef DMEM_RANGE_CHECK_EN
   assign range_err = 1'b0;
`endif

   // Behavioural memory: DMEM[i]=i, except word 0 which gets a distinctive value.
   assign mem_read_data = dmem[mem_addr[7:0]];
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) dmem[i] <= (i == 0) ? 32'hC0DE_0000 : 32'(i);
      end else if (mem_memwrite) begin
         dmem[mem_addr[7:0]] <= mem_write_data;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   // Observations from one transaction.
   int          lat, sc, rc, wc;
   logic [31:0] ws, as_seen, rd, rda;
   logic        me, re, sr, ra;

   task automatic do_req(input logic wr, input logic rdf, input logic [1:0] sz,
                         input logic sg, input logic [31:0] addr, input logic [31:0] wd);
      @(negedge clk);
      req_valid = 1'b1; req_write = wr; req_read = rdf; req_size = sz;
      req_signed = sg; req_addr = addr; req_wdata = wd;
      lat = 0; sc = 0; rc = 0; wc = 0;
      ws = '0; as_seen = '0; rd = '0; me = 1'b0; re = 1'b0; sr = 1'b1;
      for (int c = 0; c < 8; c++) begin
         #1;
         if (stall) sc++;
         if (mem_memread) begin rc++; as_seen = mem_addr; end
         if (mem_memwrite) begin wc++; ws = mem_write_data; as_seen = mem_addr; end
         @(posedge clk); #1;
         req_valid = 1'b0; req_write = 1'b0; req_read = 1'b0;
         if (resp_valid) begin
            lat = c + 1; rd = resp_rdata; me = misalign_err; re = range_err; sr = stall;
            break;
         end
         @(negedge clk);
      end
      @(posedge clk); #1;
      ra  = resp_valid;
      rda = resp_rdata;
   endtask

   initial begin
      logic seen;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_stall", stall, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_rdata", resp_rdata, 0);
      check("rst_misalign", misalign_err, 0);
      check("rst_memrd_memwr", {mem_memread, mem_memwrite}, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_write_data, 0);
      rst = 1'b1;
      mem_init = 1'b0;

      // Word load 0x18 -> DMEM[6]=6
      do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h18, 32'h0);
      check("wl_latency", lat, 2);
      check("wl_stall_cycles", sc, 2);
      check("wl_rd_cycles", rc, 1);
      check("wl_wr_cycles", wc, 0);
      check("wl_mem_addr", as_seen, 6);
      check("wl_rdata", rd, 32'h0000_0006);
      check("wl_misalign", me, 0);
      check("wl_stall_in_resp", sr, 0);
      check("wl_resp_one_cycle", ra, 0);
      check("wl_rdata_hold", rda, 32'h0000_0006);

      // Byte store 0xAB to 0x19 (read-modify-write of DMEM[6])
      do_req(1'b1, 1'b0, 2'b00, 1'b0, 32'h19, 32'hFFFF_FFAB);
      check("bs_latency", lat, 3);
      check("bs_stall_cycles", sc, 3);
      check("bs_rd_cycles", rc, 1);
      check("bs_wr_cycles", wc, 1);
      check("bs_wdata", ws, 32'h0000_AB06);
      check("bs_mem_addr", as_seen, 6);
      check("bs_rdata_zero", rd, 0);
      check("bs_dmem6", dmem[6], 32'h0000_AB06);

      do_req(1'b0, 1'b1, 2'b00, 1'b1, 32'h19, 32'h0);
      check("lb_signed", rd, 32'hFFFF_FFAB);
      do_req(1'b0, 1'b1, 2'b00, 1'b0, 32'h19, 32'h0);
      check("lbu", rd, 32'h0000_00AB);

      // Half store 0x1234 to 0x1E (upper half of DMEM[7])
      do_req(1'b1, 1'b0, 2'b01, 1'b0, 32'h1E, 32'h0000_1234);
      check("hs_hi_wdata", ws, 32'h1234_0007);
      check("hs_hi_dmem7", dmem[7], 32'h1234_0007);
      do_req(1'b0, 1'b1, 2'b01, 1'b1, 32'h1C, 32'h0);
      check("lh_lo", rd, 32'h0000_0007);
      do_req(1'b0, 1'b1, 2'b01, 1'b1, 32'h1E, 32'h0);
      check("lh_hi", rd, 32'h0000_1234);

      // Half store to lower lanes, upper store-data bits must be dropped
      do_req(1'b1, 1'b0, 2'b01, 1'b0, 32'h1C, 32'hFFFF_8001);
      check("hs_lo_dmem7", dmem[7], 32'h1234_8001);
      do_req(1'b0, 1'b1, 2'b01, 1'b1, 32'h1C, 32'h0);
      check("lh_neg", rd, 32'hFFFF_8001);
      do_req(1'b0, 1'b1, 2'b01, 1'b0, 32'h1C, 32'h0);
      check("lhu", rd, 32'h0000_8001);
      do_req(1'b0, 1'b1, 2'b00, 1'b1, 32'h1D, 32'h0);
      check("lb_lane1_neg", rd, 32'hFFFF_FF80);
      do_req(1'b0, 1'b1, 2'b00, 1'b0, 32'h1F, 32'h0);
      check("lbu_lane3", rd, 32'h0000_0012);

      // Size 11 behaves as word; word store skips the read phase
      do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h24, 32'hDEAD_BEEF);
      check("ws_latency", lat, 2);
      check("ws_rd_cycles", rc, 0);
      check("ws_wr_cycles", wc, 1);
      check("ws_dmem9", dmem[9], 32'hDEAD_BEEF);
      do_req(1'b0, 1'b1, 2'b11, 1'b1, 32'h24, 32'h0);
      check("lw_size3", rd, 32'hDEAD_BEEF);

      // Read and write both set: treated as a store
      do_req(1'b1, 1'b1, 2'b00, 1'b0, 32'h28, 32'h0000_0055);
      check("rw_latency", lat, 3);
      check("rw_wr_cycles", wc, 1);
      check("rw_dmem10", dmem[10], 32'h0000_0055);

      // Misaligned word load and misaligned half store
      do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h1A, 32'h0);
      check("mis_wl_latency", lat, 1);
      check("mis_wl_err", me, 1);
      check("mis_wl_rdata", rd, 0);
      check("mis_wl_strobes", rc + wc, 0);
      check("mis_wl_stall_cycles", sc, 1);
      check("mis_err_one_cycle", misalign_err, 0);
      do_req(1'b1, 1'b0, 2'b01, 1'b0, 32'h1B, 32'h0000_FFFF);
      check("mis_hs_latency", lat, 1);
      check("mis_hs_err", me, 1);
      check("mis_hs_wr_cycles", wc, 0);
      check("mis_hs_dmem6", dmem[6], 32'h0000_AB06);

      // Valid without read/write flags: ignored, no stall
      @(negedge clk);
      req_valid = 1'b1; req_read = 1'b0; req_write = 1'b0; req_addr = 32'h18;
      #1;
      check("noop_stall", stall, 0);
      seen = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (resp_valid || stall || mem_memread || mem_memwrite) seen = 1'b1;
      end
      check("noop_ignored", seen, 0);
      req_valid = 1'b0;

      // Address beyond 4*DEPTH
      do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h400, 32'h0);
`ifdef DMEM_RANGE_CHECK_EN
      check("rng_latency", lat, 1);
      check("rng_err", re, 1);
      check("rng_misalign", me, 0);
      check("rng_rd_cycles", rc, 0);
      check("rng_rdata", rd, 0);
      do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h402, 32'h0);
      check("rng_mis_both", {re, me}, 2'b11);
`else
      check("wrap_latency", lat, 2);
      check("wrap_mem_addr", as_seen, 0);
      check("wrap_rdata", rd, 32'hC0DE_0000);
      check("wrap_no_range_err", re, 0);
`endif

      // Reset during RD of a byte store to 0x20: the write must be abandoned
      do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h24, 32'h0);
      check("pre_rst_rdata", rd, 32'hDEAD_BEEF);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_read = 1'b0; req_size = 2'b00;
      req_addr = 32'h20; req_wdata = 32'h0000_0077;
      @(posedge clk); #1;
      req_valid = 1'b0; req_write = 1'b0;
      check("mrst_in_rd", mem_memread, 1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("mrst_stall", stall, 0);
      check("mrst_strobes", {mem_memread, mem_memwrite}, 0);
      check("mrst_mem_addr", mem_addr, 0);
      check("mrst_mem_wdata", mem_write_data, 0);
      check("mrst_resp", {resp_valid, misalign_err}, 0);
      check("mrst_rdata", resp_rdata, 0);
      seen = 1'b0;
      repeat (2) begin @(negedge clk); if (mem_memwrite) seen = 1'b1; end
      rst = 1'b1;
      repeat (3) begin @(negedge clk); if (mem_memwrite || stall) seen = 1'b1; end
      check("mrst_no_write", seen, 0);
      check("mrst_dmem8", dmem[8], 32'h0000_0008);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

   // Global time bound so the bench can never hang.
   initial begin
      #200000;
      $display("FAIL timeout: got=running expected=finished");
      $fatal(1);
   end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- MEM-stage access controller between the EX/MEM pipeline latch and the word-organised data memory (256 x 32, combinational read, word-indexed address).
- Accepts byte-addressed load/store requests of byte, halfword or word size.
- Performs lane extraction with sign/zero extension on loads, and a read-modify-write for sub-word stores.
- Stalls the pipeline while an access is in flight.

Parameters:
DEPTH, 256, number of 32-bit words in data memory
ADDR_W, 8, word-index bits (log2 DEPTH)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-low reset
req_valid  input  1  EX/MEM holds a memory op this cycle
req_write  input  1  store request
req_read  input  1  load request
req_size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word
req_signed  input  1  sign-extend load result (byte/half only)
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
stall  output  1  freeze PC, IF/ID, ID/EX, EX/MEM
resp_valid  output  1  one-cycle pulse, access complete
resp_rdata  output  32  extended load data, valid with resp_valid
misalign_err  output  1  valid with resp_valid
mem_addr  output  32  word index to memory: {0, latched addr[ADDR_W+1:2]}
mem_write_data  output  32  full word to memory
mem_memwrite  output  1  memory write strobe
mem_memread  output  1  memory read enable
mem_read_data  input  32  memory word output, combinational from mem_addr

Behaviour:
- States: IDLE, RD, WR, RESP. Reset (rst=0 at edge) forces IDLE.
- Reset values: resp_valid=0, resp_rdata=0, misalign_err=0, mem_memwrite=0, mem_memread=0, mem_addr=0, mem_write_data=0.
- Memory-side outputs are Moore outputs decoded from state plus latched registers.
- Accept: in IDLE with req_valid and (req_read or req_write), latch addr, size, signed and wdata.
- req_write and req_read both set: treated as a store.
- Neither set: request ignored, no stall.
- stall = (IDLE and accepted request) or state in {RD, WR}. stall=0 in RESP, so EX/MEM advances on the RESP edge.
- Alignment: half with addr[0]=1, or word with addr[1:0]!=0, is misaligned.
  - IDLE -> RESP directly.
  - misalign_err=1, resp_rdata=0.
  - No memread or memwrite is ever asserted.
- Load: IDLE -> RD -> RESP.
  - RD: mem_memread=1; capture mem_read_data at the RD->RESP edge.
  - resp_valid high 2 cycles after the accept edge.
- Word store: IDLE -> WR -> RESP.
  - WR: mem_memwrite=1 for exactly one cycle, mem_write_data=req_wdata.
- Sub-word store: IDLE -> RD -> WR -> RESP.
  - RD captures the old word.
  - WR writes the merged word: byte/half lanes replaced, others preserved.
- Lanes are little-endian: lane k = bits 8k+7:8k, selected by addr[1:0]; half uses addr[1] (lanes 0-1 or 2-3).
- Load extract: byte/half shifted to bit 0, then sign-extended if req_signed, else zero-extended. Word loads ignore req_signed.
- RESP: resp_valid=1 for one cycle, then IDLE unconditionally. A new request is never accepted in RESP; the next one is seen in the following IDLE cycle.
- resp_rdata holds its value until the next RESP. It is 0 after store responses.
- Reset mid-operation: state -> IDLE at that edge; any pending WR is abandoned, so memory is unchanged if reset hits in RD. stall drops after reset.
- mem_addr wraps within DEPTH: address bits above ADDR_W+1 are ignored (unless the optional feature is compiled in).

Optional Feature:
- Macro DMEM_RANGE_CHECK_EN.
- Defined:
  - Adds output range_err (1 bit), valid with resp_valid.
  - A request with req_addr >= 4*DEPTH goes IDLE -> RESP with range_err=1, resp_rdata=0 and no memory strobes.
  - If misalignment also applies, misalign_err=1 as well.
- Undefined:
  - No range_err port.
  - Upper address bits are silently ignored; the address wraps.

Test Plan:
- Word load req_addr=0x18 (DMEM[6]=6): stall high 2 cycles, mem_memread in RD, resp_valid at accept+2, resp_rdata=0x00000006.
- Byte store 0xAB to 0x19, then signed byte load 0x19: one mem_memwrite pulse with mem_write_data=0x0000AB06 at accept+2, resp_valid at accept+3; load returns 0xFFFFFFAB, and the unsigned load returns 0x000000AB.
- Half store 0x1234 to 0x1E (DMEM[7]=7): memory word becomes 0x12340007; signed half load 0x1C returns 0x00000007.
- Word load 0x1A: resp_valid at accept+1, misalign_err=1, resp_rdata=0, mem_memread and mem_memwrite never asserted.
- Byte store to 0x20 with rst=0 during RD: no mem_memwrite pulse, DMEM[8] stays 8, all outputs return to reset values on that edge.
- With DMEM_RANGE_CHECK_EN, load 0x400: range_err=1 at accept+1, no memread. Without the macro, the same request reads DMEM[0].
